// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the 3-bit-opcode processor.
// Steps each instruction through FETCH / DECODE / EXEC / MEM / WB. It drives the
// shared instruction/data memory port with a req/ready handshake and a timeout.
//
// Opcode map: 000 lw, 001 sw, 010 add, 011 beq, 100 j, 101 slt, 110 illegal, 111 hlt.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   start            leave IDLE and begin fetching
//   opcode           IR opcode field, sampled in DECODE
//   zero             ALU zero flag, used in EXEC for beq
//   mem_ready        memory completes the current request this cycle
//   mem_req/mem_we/iord               memory port controls
//   ir_write/pc_write/pc_src          IR and PC load controls
//   alu_op/alu_src_a/alu_src_b        ALU controls
//   reg_write/reg_dst/wb_sel          register file write-back controls
//   halted/illegal_op/mem_timeout     status (the last two are sticky)
//   state            current state encoding
//   instr_count      retired-instruction counter (wraps)
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             wb_sel,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd7
  } state_e;

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpSw  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpBeq = 3'b011;
  localparam logic [2:0] OpJ   = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpIll = 3'b110;
  localparam logic [2:0] OpHlt = 3'b111;

  // The wait counter only has to reach MEM_TIMEOUT-1: the wait cycle seen at that
  // value is the one that trips the timeout.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
      (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

  state_e             state_q;
  logic [2:0]         op_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   instr_count_q;
  logic               illegal_q;
  logic               timeout_q;
  logic               op_is_mem;
  logic               timeout_hit;

  assign state       = state_q;
  assign instr_count = instr_count_q;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

  assign op_is_mem   = (op_q == OpLw) || (op_q == OpSw);
  // mem_ready in the same cycle wins over the timeout.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_op    = 3'b000;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      StDecode: begin
        // Jumps resolve here from the live opcode, before it is latched.
        if (opcode == OpJ) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
      end
      StExec: begin
        alu_op    = op_is_mem ? 3'b000 : op_q;
        alu_src_a = 1'b1;
        alu_src_b = !op_is_mem;
        if (op_q == OpBeq && zero) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (op_q == OpSw);
      end
      StWb: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OpLw);
        wb_sel    = (op_q == OpLw);
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= 3'b000;
      wait_q        <= '0;
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      if (MEM_TIMEOUT != 0 && mem_req && !mem_ready) begin
        wait_q <= wait_q + 1'b1;
      end else begin
        wait_q <= '0;
      end

      case (state_q)
        StIdle: begin
          if (start) state_q <= StFetch;
        end
        StFetch: begin
          if (mem_ready) begin
            state_q <= StDecode;
          end else if (timeout_hit) begin
            state_q   <= StHalt;
            timeout_q <= 1'b1;
          end
        end
        StDecode: begin
          op_q <= opcode;
          case (opcode)
            OpJ: begin
              state_q       <= StFetch;
              instr_count_q <= instr_count_q + 1'b1;
            end
            OpHlt: state_q <= StHalt;
            OpIll: begin
              state_q   <= StHalt;
              illegal_q <= 1'b1;
            end
            default: state_q <= StExec;
          endcase
        end
        StExec: begin
          case (op_q)
            OpLw, OpSw:   state_q <= StMem;
            OpAdd, OpSlt: state_q <= StWb;
            default: begin
              // beq retires here whether or not the branch is taken.
              state_q       <= StFetch;
              instr_count_q <= instr_count_q + 1'b1;
            end
          endcase
        end
        StMem: begin
          if (mem_ready) begin
            if (op_q == OpSw) begin
              state_q       <= StFetch;
              instr_count_q <= instr_count_q + 1'b1;
            end else begin
              state_q <= StWb;
            end
          end else if (timeout_hit) begin
            state_q   <= StHalt;
            timeout_q <= 1'b1;
          end
        end
        StWb: begin
          state_q       <= StFetch;
          instr_count_q <= instr_count_q + 1'b1;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed vector bench for multicycle_control_fsm (MEM_TIMEOUT=4, CNT_W=4).
// Each vector drives inputs shortly after a rising edge and checks state, the control
// word and instr_count on the following falling edge.
module tb_multicycle_control_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       alu_src_a, alu_src_b, reg_write, reg_dst, wb_sel;
  logic       halted, illegal_op, mem_timeout;
  logic [2:0] state;
  logic [3:0] instr_count;

  multicycle_control_fsm #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .wb_sel     (wb_sel),
    .halted     (halted),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout),
    .state      (state),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  logic [17:0] act_ctl;
  assign act_ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_op,
                    alu_src_a, alu_src_b, reg_write, reg_dst, wb_sel,
                    halted, illegal_op, mem_timeout};

  localparam logic [17:0] REQ    = 18'h20000;
  localparam logic [17:0] WE     = 18'h10000;
  localparam logic [17:0] IORD   = 18'h08000;
  localparam logic [17:0] IRW    = 18'h04000;
  localparam logic [17:0] PCW    = 18'h02000;
  localparam logic [17:0] PCS_J  = 18'h01000;
  localparam logic [17:0] PCS_BR = 18'h00800;
  localparam logic [17:0] ALU_A  = 18'h00200;  // alu_op 010
  localparam logic [17:0] ALU_B  = 18'h00300;  // alu_op 011
  localparam logic [17:0] ALU_S  = 18'h00500;  // alu_op 101
  localparam logic [17:0] SA     = 18'h00080;
  localparam logic [17:0] SB     = 18'h00040;
  localparam logic [17:0] RW     = 18'h00020;
  localparam logic [17:0] DST    = 18'h00010;
  localparam logic [17:0] WBS    = 18'h00008;
  localparam logic [17:0] HLTD   = 18'h00004;
  localparam logic [17:0] ILL    = 18'h00002;
  localparam logic [17:0] TMO    = 18'h00001;
  localparam logic [17:0] FDONE  = REQ | IRW | PCW;
  localparam logic [17:0] JDEC   = PCW | PCS_J;

  localparam logic [2:0] LW = 3'd0, SW = 3'd1, ADD = 3'd2, BEQ = 3'd3;
  localparam logic [2:0] J = 3'd4, SLT = 3'd5, IL = 3'd6, HLT = 3'd7;

  typedef struct {
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        zero;
    logic        rdy;
    logic [2:0]  st;
    logic [17:0] ctl;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_miscompares = 0;

  task automatic add(input logic rst, input logic st_in, input logic [2:0] op,
                     input logic z, input logic rdy, input logic [2:0] st,
                     input logic [17:0] ctl, input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.start = st_in; v.op = op; v.zero = z; v.rdy = rdy;
    v.st = st; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(posedge clock);
    #1;
    reset = v.rst; start = v.start; opcode = v.op; zero = v.zero; mem_ready = v.rdy;
    @(negedge clock);
    n_applied++;
    if ({state, act_ctl, instr_count} !== {v.st, v.ctl, v.cnt}) begin
      n_miscompares++;
      $display("FAIL %s: got state=%0d ctl=%05h cnt=%0d, expected state=%0d ctl=%05h cnt=%0d",
               name, state, act_ctl, instr_count, v.st, v.ctl, v.cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [3:0] exp_cnt;
    bit         seen;

    // rst start op z rdy | state ctl cnt
    // add, no memory waits
    add(1, 0, 0,   0, 0, 0, 18'h0, 0);
    add(0, 0, 0,   0, 0, 0, 18'h0, 0);
    add(0, 1, 0,   0, 0, 0, 18'h0, 0);
    add(0, 0, ADD, 0, 1, 1, FDONE, 0);
    add(0, 0, ADD, 0, 1, 2, 18'h0, 0);
    add(0, 0, 0,   0, 1, 3, ALU_A | SA | SB, 0);  // live opcode changed; latched add used
    add(0, 0, 0,   0, 1, 5, RW, 0);
    // lw with 3 wait cycles; the 4th MEM cycle is the timeout boundary and ready wins
    add(0, 0, LW,  0, 1, 1, FDONE, 1);
    add(0, 0, LW,  0, 0, 2, 18'h0, 1);
    add(0, 0, 0,   0, 0, 3, SA, 1);
    add(0, 0, 0,   0, 0, 4, REQ | IORD, 1);
    add(0, 0, 0,   0, 0, 4, REQ | IORD, 1);
    add(0, 0, 0,   0, 0, 4, REQ | IORD, 1);
    add(0, 0, 0,   0, 1, 4, REQ | IORD, 1);
    add(0, 0, 0,   0, 0, 5, RW | DST | WBS, 1);
    // beq taken, with one fetch wait cycle
    add(0, 0, BEQ, 0, 0, 1, REQ, 2);
    add(0, 0, BEQ, 0, 1, 1, FDONE, 2);
    add(0, 0, BEQ, 0, 0, 2, 18'h0, 2);
    add(0, 0, 0,   1, 0, 3, ALU_B | SA | SB | PCW | PCS_BR, 2);
    // beq not taken
    add(0, 0, BEQ, 1, 1, 1, FDONE, 3);
    add(0, 0, BEQ, 1, 0, 2, 18'h0, 3);
    add(0, 0, 0,   0, 0, 3, ALU_B | SA | SB, 3);
    // sw
    add(0, 0, SW,  0, 1, 1, FDONE, 4);
    add(0, 0, SW,  0, 0, 2, 18'h0, 4);
    add(0, 0, 0,   0, 0, 3, SA, 4);
    add(0, 0, 0,   0, 1, 4, REQ | IORD | WE, 4);
    // slt
    add(0, 0, SLT, 0, 1, 1, FDONE, 5);
    add(0, 0, SLT, 0, 0, 2, 18'h0, 5);
    add(0, 0, 0,   0, 0, 3, ALU_S | SA | SB, 5);
    add(0, 0, 0,   0, 0, 5, RW, 5);
    // j then hlt; start is ignored in HALT
    add(0, 0, J,   0, 1, 1, FDONE, 6);
    add(0, 0, J,   0, 0, 2, JDEC, 6);
    add(0, 0, HLT, 0, 1, 1, FDONE, 7);
    add(0, 0, HLT, 0, 0, 2, 18'h0, 7);
    add(0, 1, 0,   0, 1, 7, HLTD, 7);
    add(0, 1, 0,   0, 0, 7, HLTD, 7);
    // illegal opcode
    add(1, 0, 0,   0, 0, 0, 18'h0, 0);
    add(0, 1, 0,   0, 0, 0, 18'h0, 0);
    add(0, 0, IL,  0, 1, 1, FDONE, 0);
    add(0, 0, IL,  0, 0, 2, 18'h0, 0);
    add(0, 1, 0,   0, 0, 7, HLTD | ILL, 0);
    // sw that times out after 4 wait cycles
    add(1, 0, 0,   0, 0, 0, 18'h0, 0);
    add(0, 1, 0,   0, 0, 0, 18'h0, 0);
    add(0, 0, SW,  0, 1, 1, FDONE, 0);
    add(0, 0, SW,  0, 0, 2, 18'h0, 0);
    add(0, 0, 0,   0, 0, 3, SA, 0);
    add(0, 0, 0,   0, 0, 4, REQ | IORD | WE, 0);
    add(0, 0, 0,   0, 0, 4, REQ | IORD | WE, 0);
    add(0, 0, 0,   0, 0, 4, REQ | IORD | WE, 0);
    add(0, 0, 0,   0, 0, 4, REQ | IORD | WE, 0);
    add(0, 0, 0,   0, 1, 7, HLTD | TMO, 0);
    add(0, 1, 0,   0, 0, 7, HLTD | TMO, 0);
    // reset during a fetch wait, then a clean restart with a fresh wait counter
    add(1, 0, 0,   0, 0, 0, 18'h0, 0);
    add(0, 1, 0,   0, 0, 0, 18'h0, 0);
    add(0, 0, 0,   0, 0, 1, REQ, 0);
    add(0, 0, 0,   0, 0, 1, REQ, 0);
    add(1, 0, 0,   0, 0, 0, 18'h0, 0);
    add(0, 1, 0,   0, 0, 0, 18'h0, 0);
    add(0, 0, 0,   0, 0, 1, REQ, 0);
    add(0, 0, 0,   0, 0, 1, REQ, 0);
    add(0, 0, 0,   0, 0, 1, REQ, 0);
    add(0, 0, J,   0, 1, 1, FDONE, 0);
    add(0, 0, J,   0, 0, 2, JDEC, 0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // 15 more jumps wrap the 4-bit counter from 1 back to 0
    exp_cnt = 4'd1;
    for (int i = 0; i < 15; i++) begin
      v.rst = 0; v.start = 0; v.op = J; v.zero = 0; v.rdy = 1;
      v.st = 1; v.ctl = FDONE; v.cnt = exp_cnt;
      run_vec(v, $sformatf("wrap_fetch%0d", i));
      v.rdy = 0; v.st = 2; v.ctl = JDEC;
      run_vec(v, $sformatf("wrap_decode%0d", i));
      exp_cnt = exp_cnt + 4'd1;
    end
    v.rst = 0; v.start = 0; v.op = HLT; v.zero = 0; v.rdy = 1;
    v.st = 1; v.ctl = FDONE; v.cnt = 4'd0;
    run_vec(v, "wrap_done");
    v.rdy = 0; v.st = 2; v.ctl = 18'h0;
    run_vec(v, "hlt_decode");

    // bounded wait for HALT; hlt must not retire
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clock);
      if (state == 3'd7) seen = 1'b1;
    end
    n_applied++;
    if (!seen || act_ctl !== HLTD || instr_count !== 4'd0) begin
      n_miscompares++;
      $display("FAIL hlt_final: got seen=%0d state=%0d ctl=%05h cnt=%0d, expected state=7 ctl=%05h cnt=0",
               seen, state, act_ctl, instr_count, HLTD);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle sequencer for the 3-bit-opcode processor (lw, sw, add, beq, j, slt, hlt).
- Replaces single-cycle decode with a state machine: FETCH, DECODE, EXEC, MEM, WB.
- Drives the shared instruction/data memory port with a req/ready handshake, including timeout detection.
- Sits between the instruction register, ALU, register file, PC logic and the single memory port.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may wait for mem_ready; 0 disables timeout.
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- opcode  in  3  IR[opcode] field, valid in DECODE
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (sw data phase)
- iord  out  1  address select: 0 = PC, 1 = ALU result
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- alu_op  out  3  equals opcode encoding of executing instruction (000 for lw/sw address add)
- alu_src_a  out  1  1 = register rs, 0 = PC
- alu_src_b  out  1  1 = register rt, 0 = immediate
- reg_write  out  1  register file write strobe
- reg_dst  out  1  1 = rt (lw), 0 = rd (add/slt)
- wb_sel  out  1  1 = memory data, 0 = ALU result
- halted  out  1  in HALT state
- illegal_op  out  1  sticky: opcode 110 decoded
- mem_timeout  out  1  sticky: handshake timeout
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7
- instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W

Behaviour:
Reset:
- state = IDLE; all strobes 0; pc_src, alu_op 0.
- instr_count, illegal_op, mem_timeout, latched opcode and wait counter all 0.
- Reset is honoured in any state, including mid-handshake; mem_req drops immediately.

Output timing:
- Outputs are combinational from state, latched opcode, zero and mem_ready.
- Everything not listed for a state is 0.

States and transitions:
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1, iord=0. ir_write=1, pc_write=1 and pc_src=00 only in the cycle mem_ready=1; that cycle -> DECODE, else stay.
- DECODE: opcode captured into an internal register on exit; later states use the latched value only.
  - j: pc_write=1, pc_src=10, retire -> FETCH.
  - hlt -> HALT.
  - 110 -> HALT, set illegal_op.
  - others -> EXEC.
- EXEC: alu_op = latched opcode, except 000 for lw/sw.
  - lw/sw: alu_src_a=1, alu_src_b=0 -> MEM.
  - add/slt: alu_src_a=1, alu_src_b=1 -> WB.
  - beq: alu_src_a=1, alu_src_b=1; if zero: pc_write=1, pc_src=01. Retire -> FETCH either way.
- MEM: mem_req=1, iord=1, mem_we=1 for sw. Wait for mem_ready.
  - sw: retire -> FETCH.
  - lw: -> WB.
- WB: reg_write=1; reg_dst=1 and wb_sel=1 for lw, 0 for add/slt; retire -> FETCH.
- HALT: halted=1; absorbing until reset; start ignored.

Retire:
- instr_count += 1 in the cycle of the retiring transition.
- hlt and illegal opcodes do not count.

Latency:
- Handshake-free cycle counts: j 2, beq 3, add/slt 4, sw 4, lw 5.
- Each memory wait cycle adds 1.

Timeout:
- Wait counter increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or on leaving the state.
- When the counter reaches MEM_TIMEOUT (non-zero) -> HALT, set mem_timeout; the pending request is abandoned.

Boundaries:
- mem_ready outside FETCH/MEM is ignored.
- mem_ready=1 in the same cycle the timeout is reached: ready wins.
- instr_count wraps silently.

Test Plan:
- Reset, start=1, opcode=010, mem_ready=1 always -> states 1,2,3,5,1; reg_write=1 only in WB with reg_dst=0, wb_sel=0; instr_count=1 after 4 cycles.
- lw with mem_ready held 0 for 3 cycles in MEM -> MEM lasts 4 cycles with iord=1, mem_we=0; then WB with reg_dst=1, wb_sel=1; retire at cycle 8.
- beq with zero=1, then beq with zero=0 -> first gives pc_write=1, pc_src=01 in EXEC; second gives pc_write=0; instr_count=2.
- j then hlt -> DECODE pc_src=10, pc_write=1; then HALT, halted=1, instr_count=1; start pulses are ignored.
- opcode 110 -> HALT with illegal_op=1, instr_count unchanged; sw with MEM_TIMEOUT=4 and mem_ready=0 -> HALT after 4 wait cycles, mem_timeout=1, mem_we drops.
- Assert reset during a FETCH wait -> same cycle: state=0, mem_req=0, counters and flags 0; start restarts cleanly.
